// File: rtl/speed_meter.sv
// rtl/speed_meter.sv - gated edge-rate meter that decodes the measured rate into a 2-bit speed mode
// Define SPEED_METER_HYST_EN to require two consecutive windows of a new class before mode moves.
module speed_meter #(
  parameter int GATE_CYCLES = 100000,
  parameter int CW          = 16,
  parameter int TH_SLOW     = 16,
  parameter int TH_MED      = 800,
  parameter int TH_FAST     = 2400
) (
  input  logic          clk_100mhz,
  input  logic          rst,
  input  logic          sig_in,
  output logic [CW-1:0] count,
  output logic          count_valid,
  output logic [1:0]    mode,
  output logic          mode_changed
);

  localparam int            GW      = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] G_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] ACC_MAX = '1;
  localparam logic [CW-1:0] T_SLOW  = CW'(TH_SLOW);
  localparam logic [CW-1:0] T_MED   = CW'(TH_MED);
  localparam logic [CW-1:0] T_FAST  = CW'(TH_FAST);

  logic          s1, s2, s3;
  logic          rise;
  logic [GW-1:0] gcnt;
  logic          terminal;
  logic [CW-1:0] acc, acc_next;
  logic [1:0]    cls;
  logic [1:0]    mode_nx;
  logic          chg_nx;

  assign rise     = s2 & ~s3;
  assign terminal = (gcnt == G_LAST);

  // acc_next already includes an edge landing on the terminal cycle
  always_comb begin
    acc_next = acc;
    if (rise && acc != ACC_MAX)
      acc_next = acc + 1'b1;
  end

  always_comb begin
    if (acc_next < T_SLOW)
      cls = 2'd0;
    else if (acc_next < T_MED)
      cls = 2'd1;
    else if (acc_next < T_FAST)
      cls = 2'd2;
    else
      cls = 2'd3;
  end

`ifdef SPEED_METER_HYST_EN
  typedef enum logic {STABLE, CAND} state_t;

  state_t     state, state_nx;
  logic [1:0] cand_mode, cand_nx;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state     <= STABLE;
      cand_mode <= 2'd0;
    end else begin
      state     <= state_nx;
      cand_mode <= cand_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cand_nx  = cand_mode;
    mode_nx  = mode;
    chg_nx   = 1'b0;
    if (terminal) begin
      case (state)
        STABLE: begin
          if (cls != mode) begin
            cand_nx  = cls;
            state_nx = CAND;
          end
        end
        CAND: begin
          if (cls == cand_mode) begin
            mode_nx  = cls;
            chg_nx   = 1'b1;
            state_nx = STABLE;
          end else if (cls == mode) begin
            state_nx = STABLE;
          end else begin
            cand_nx = cls;
          end
        end
        default: state_nx = STABLE;
      endcase
    end
  end
`else
  always_comb begin
    mode_nx = cls;
    chg_nx  = (cls != mode);
  end
`endif

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      gcnt         <= '0;
      acc          <= '0;
      count        <= '0;
      count_valid  <= 1'b0;
      mode         <= 2'd0;
      mode_changed <= 1'b0;
    end else begin
      s1           <= sig_in;
      s2           <= s1;
      s3           <= s2;
      count_valid  <= terminal;
      mode_changed <= terminal & chg_nx;
      if (terminal) begin
        gcnt  <= '0;
        acc   <= '0;
        count <= acc_next;
        mode  <= mode_nx;
      end else begin
        gcnt <= gcnt + 1'b1;
        acc  <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_speed_meter.sv
// tb/tb_speed_meter.sv - scoreboard bench for speed_meter (16-bit and saturating 4-bit instances)
// Expected mode follows SPEED_METER_HYST_EN in the same way as the design.
module tb_speed_meter;

  localparam int G = 100;

  logic        clk_100mhz = 1'b0;
  logic        rst        = 1'b1;
  logic        sig_in     = 1'b0;
  logic [15:0] count_a;
  logic        cv_a;
  logic [1:0]  mode_a;
  logic        mc_a;
  logic [3:0]  count_b;
  logic        cv_b;
  logic [1:0]  mode_b;
  logic        mc_b;

  always #5 clk_100mhz = ~clk_100mhz;

  speed_meter #(.GATE_CYCLES(G), .CW(16), .TH_SLOW(2), .TH_MED(8), .TH_FAST(15)) dut_a (
    .clk_100mhz(clk_100mhz), .rst(rst), .sig_in(sig_in),
    .count(count_a), .count_valid(cv_a), .mode(mode_a), .mode_changed(mc_a)
  );

  speed_meter #(.GATE_CYCLES(G), .CW(4), .TH_SLOW(2), .TH_MED(8), .TH_FAST(15)) dut_b (
    .clk_100mhz(clk_100mhz), .rst(rst), .sig_in(sig_in),
    .count(count_b), .count_valid(cv_b), .mode(mode_b), .mode_changed(mc_b)
  );

  typedef struct {
    int          t;
    logic [15:0] ca;
    logic [3:0]  cb;
    logic [1:0]  m;
    logic        mc;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nerr = 0;

  // Posedges are numbered from 1 after reset release; edge 1 sees gcnt == 0.
  int   t_next   = 1;
  int   t_last   = 0;
  bit   armed    = 1'b0;
  bit   rst_last = 1'b1;
  bit   done     = 1'b0;
  bit   drained  = 1'b0;
  logic prev     = 1'b0;
  int   wcnt[0:63];

  // Reference mode tracker
  logic [1:0] m_mode = 2'd0;
  logic [1:0] m_cand = 2'd0;
  bit         m_in_cand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] classify(input int n);
    if (n < 2)  return 2'd0;
    if (n < 8)  return 2'd1;
    if (n < 15) return 2'd2;
    return 2'd3;
  endfunction

  task automatic push_window(input int k);
    exp_t       e;
    int         n;
    logic [1:0] c;
    n    = wcnt[k];
    e.t  = t_last;
    e.ca = (n > 65535) ? 16'hffff : 16'(n);
    e.cb = (n > 15) ? 4'hf : 4'(n);
    c    = classify(n);
    e.mc = 1'b0;
`ifdef SPEED_METER_HYST_EN
    if (!m_in_cand) begin
      if (c != m_mode) begin
        m_cand    = c;
        m_in_cand = 1'b1;
      end
    end else if (c == m_cand) begin
      m_mode    = c;
      e.mc      = 1'b1;
      m_in_cand = 1'b0;
    end else if (c == m_mode) begin
      m_in_cand = 1'b0;
    end else begin
      m_cand = c;
    end
`else
    e.mc   = (c != m_mode);
    m_mode = c;
`endif
    e.m = m_mode;
    q.push_back(e);
  endtask

  // One clock: drive at negedge, book-keep after posedge. A rise first sampled
  // at posedge t is seen by the accumulator at posedge t+2.
  task automatic cycle(input logic v, input logic r);
    @(negedge clk_100mhz);
    rst    = r;
    sig_in = v;
    if (!r && v && !prev)
      wcnt[(t_next + 1) / G + 1]++;
    prev = r ? 1'b0 : v;
    @(posedge clk_100mhz);
    armed    = 1'b1;
    rst_last = r;
    if (r) begin
      t_last    = 0;
      t_next    = 1;
      m_mode    = 2'd0;
      m_cand    = 2'd0;
      m_in_cand = 1'b0;
      for (int i = 0; i < 64; i++) wcnt[i] = 0;
    end else begin
      t_last = t_next;
      t_next++;
      if (t_last % G == 0)
        push_window(t_last / G);
    end
  endtask

  task automatic run_period(input int per, input int n);
    for (int i = 0; i < n; i++)
      cycle(((i % per) < (per / 2)), 1'b0);
  endtask

  task automatic run_const(input logic v, input int n);
    for (int i = 0; i < n; i++)
      cycle(v, 1'b0);
  endtask

  always @(negedge clk_100mhz) begin
    exp_t e;
    if (armed) begin
      if (rst_last) begin
        chk("reset count_a", count_a, 0);
        chk("reset count_b", count_b, 0);
        chk("reset count_valid", cv_a, 0);
        chk("reset mode", mode_a, 0);
        chk("reset mode_changed", mc_a, 0);
      end else if (q.size() != 0 && q[0].t == t_last) begin
        e = q.pop_front();
        chk("count_valid_a", cv_a, 1);
        chk("count_valid_b", cv_b, 1);
        chk("count_a", count_a, e.ca);
        chk("count_b_sat", count_b, e.cb);
        chk("mode_a", mode_a, e.m);
        chk("mode_b", mode_b, e.m);
        chk("mode_changed_a", mc_a, e.mc);
        chk("mode_changed_b", mc_b, e.mc);
      end else begin
        chk("idle count_valid_a", cv_a, 0);
        chk("idle count_valid_b", cv_b, 0);
        chk("idle mode_changed_a", mc_a, 0);
      end
      if (done && !drained) begin
        chk("scoreboard drained", q.size(), 0);
        drained = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) wcnt[i] = 0;

    // Reset, then a quiet first window: first count_valid after posedge 100
    repeat (5) cycle(1'b0, 1'b1);
    run_const(1'b0, G);

    // Steady period 10, then one window of period 5, then period 10 again
    run_period(10, 3 * G);
    run_period(5, G);
    run_period(10, 2 * G);

    // Terminal-edge boundary: rise counted on the terminal cycle, then one just after it
    run_const(1'b0, G);
    while (t_next % G != G - 2) cycle(1'b0, 1'b0);
    run_const(1'b1, 10);
    while (t_next % G != G - 1) cycle(1'b0, 1'b0);
    run_const(1'b1, 10);
    run_const(1'b0, 2 * G);

    // Saturation: 25 edges per window overflows the 4-bit instance
    run_period(4, 3 * G);

    // Reset at cycle 50 of a window while edges arrive
    while (t_next % G != 50) cycle((t_next % 4) < 2, 1'b0);
    repeat (3) cycle(1'b1, 1'b1);
    run_period(10, 2 * G);

    // Reset landing on a terminal cycle suppresses that count_valid
    while (t_next % G != 0) cycle((t_next % 10) < 5, 1'b0);
    repeat (2) cycle(1'b0, 1'b1);
    run_const(1'b0, G + 3);

    done = 1'b1;
    repeat (3) @(posedge clk_100mhz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
